// File: rtl/fifo_loop_pkg.sv
// Shared state encoding, widths and helpers for the FIFO fill/drain loop sequencer.
package fifo_loop_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ERR_W  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    SETTLE = 3'd2,
    READ   = 3'd3,
    DONE   = 3'd4
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_loop_chk.sv
// Read-data checker: read-latency delay pipe, expected-pattern counter and saturating error count.
// Only built when FIFO_LOOP_CHK_EN is defined; the controller then instantiates it.
`ifdef FIFO_LOOP_CHK_EN
module fifo_loop_chk
  import fifo_loop_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_ld_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic              rd_acc_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              pend_c,
  output logic [ERR_W-1:0]  err_cnt_o
);

  localparam int unsigned PIPE_W = RD_LATENCY * DATA_W;

  logic [RD_LATENCY-1:0]             vld_q, vld_d;
  logic [RD_LATENCY-1:0][DATA_W-1:0] exp_pipe_q, exp_pipe_d;
  logic [DATA_W-1:0]                 exp_q, exp_d;
  logic [ERR_W-1:0]                  err_q, err_d;
  logic                              strobe_c;

  assign strobe_c  = vld_q[RD_LATENCY-1] & ~flush_i;
  assign pend_c    = |vld_q;
  assign err_cnt_o = err_q;

  // Expected byte travels down the pipe beside its strobe, so it advances per accepted read.
  always_comb begin
    vld_d      = RD_LATENCY'({vld_q, rd_acc_i});
    exp_pipe_d = PIPE_W'({exp_pipe_q, exp_q});
    exp_d      = exp_q;
    err_d      = err_q;
    if (rd_acc_i) exp_d = exp_q + DATA_W'(1);
    if (seed_ld_i) exp_d = seed_i;
    if (flush_i) vld_d = '0;
    if (strobe_c && (rd_data_i != exp_pipe_q[RD_LATENCY-1]) && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      exp_pipe_q <= '0;
      exp_q      <= '0;
      err_q      <= '0;
    end else begin
      vld_q      <= vld_d;
      exp_pipe_q <= exp_pipe_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
    end
  end

endmodule
`endif

// File: rtl/fifo_loop_ctrl.sv
// Fill/drain loop sequencer driving both ports of an 8-bit FIFO with an incrementing byte pattern.
// Define FIFO_LOOP_CHK_EN to build in read-data checking (err_cnt); otherwise err_cnt is 0.
module fifo_loop_ctrl
  import fifo_loop_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned LOOP_MAX   = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              rst_busy,
  input  logic              full,
  input  logic              empty,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  loop_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int unsigned WC_W = $clog2(BURST_LEN + 1);
  localparam int unsigned ST_W = $clog2(SETTLE_CYC + 1);

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wr_cnt_q, wr_cnt_d, wr_cnt_nx;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ST_W-1:0]   st_cnt_q, st_cnt_d;
  logic [CNT_W-1:0]  loop_q, loop_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              halt_q, halt_d;
  logic              wr_acc_c, rd_acc_c, pend_c, seed_ld_c, flush_c, go_wr;

  assign wr_acc_c  = wr_en_q & ~full;
  assign rd_acc_c  = rd_en_q & ~empty;
  assign wr_cnt_nx = wr_cnt_q + WC_W'(wr_acc_c);

  // halt_q blocks an immediate restart from IDLE after LOOP_MAX loops until start drops.
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    wr_data_d = wr_data_q;
    st_cnt_d  = st_cnt_q;
    loop_d    = loop_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    done_d    = 1'b0;
    halt_d    = halt_q & start;
    seed_ld_c = 1'b0;
    flush_c   = 1'b0;
    go_wr     = 1'b0;

    if ((state_q != IDLE) && rst_busy) begin
      state_d = IDLE;
      flush_c = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: go_wr = start & ~rst_busy & ~halt_q;
        WRITE: begin
          if (wr_acc_c) begin
            wr_cnt_d  = wr_cnt_nx;
            wr_data_d = wr_data_q + DATA_W'(1);
          end
          if ((wr_cnt_nx == WC_W'(BURST_LEN)) || full) begin
            state_d  = SETTLE;
            st_cnt_d = '0;
          end else begin
            wr_en_d = 1'b1;
          end
        end
        SETTLE: begin
          if (st_cnt_q == ST_W'(SETTLE_CYC - 1)) begin
            state_d = READ;
            rd_en_d = ~empty;
          end else begin
            st_cnt_d = st_cnt_q + ST_W'(1);
          end
        end
        READ: begin
          rd_en_d = ~empty;
          if (empty && !pend_c) begin
            state_d = DONE;
            rd_en_d = 1'b0;
            done_d  = 1'b1;
            loop_d  = sat_inc_cnt(loop_q);
          end
        end
        DONE: begin
          if (start && ((LOOP_MAX == 0) || (loop_q < CNT_W'(LOOP_MAX)))) begin
            go_wr = 1'b1;
          end else begin
            state_d = IDLE;
            halt_d  = start;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (go_wr) begin
      state_d   = WRITE;
      wr_cnt_d  = '0;
      wr_en_d   = ~full;
      seed_ld_c = 1'b1;
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      wr_data_q <= '0;
      st_cnt_q  <= '0;
      loop_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_data_q <= wr_data_d;
      st_cnt_q  <= st_cnt_d;
      loop_q    <= loop_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      halt_q    <= halt_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign fifo_rd_en   = rd_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign loop_cnt     = loop_q;

`ifdef FIFO_LOOP_CHK_EN
  fifo_loop_chk #(
    .RD_LATENCY(RD_LATENCY)
  ) u_chk (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .seed_ld_i (seed_ld_c),
    .seed_i    (wr_data_q),
    .rd_acc_i  (rd_acc_c),
    .flush_i   (flush_c),
    .rd_data_i (fifo_rd_data),
    .pend_c    (pend_c),
    .err_cnt_o (err_cnt)
  );
`else
  // READ must still wait out in-flight reads even without data checking.
  logic [RD_LATENCY-1:0] vld_q;
  logic                  unused_nochk;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= flush_c ? '0 : RD_LATENCY'({vld_q, rd_acc_c});
    end
  end

  assign pend_c       = |vld_q;
  assign err_cnt      = '0;
  assign unused_nochk = ^{fifo_rd_data, seed_ld_c};
`endif

endmodule

// File: tb/tb_fifo_loop_ctrl.sv
// Directed bench for fifo_loop_ctrl: behavioural FIFO with variable depth, 2-cycle read latency.
module tb_fifo_loop_ctrl;

  localparam int BURST  = 256;
  localparam int SETTLE = 4;
  localparam int LAT    = 2;
  localparam int LOOPS  = 3;
`ifdef FIFO_LOOP_CHK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst, start, rst_busy, full, empty;
  logic        fifo_wr_en, fifo_rd_en, busy, done;
  logic [7:0]  fifo_wr_data;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic [15:0] loop_cnt;
  logic [7:0]  err_cnt;

  fifo_loop_ctrl #(
    .BURST_LEN (BURST),
    .SETTLE_CYC(SETTLE),
    .RD_LATENCY(LAT),
    .LOOP_MAX  (LOOPS)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .rst_busy    (rst_busy),
    .full        (full),
    .empty       (empty),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .busy        (busy),
    .done        (done),
    .loop_cnt    (loop_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // FIFO model and event monitor
  logic [7:0] mem [256];
  logic [7:0] wp = 8'h00, rp = 8'h00, stage1 = 8'h00;
  logic [7:0] wr_log [$];
  int cnt = 0, depth = 256, corrupt_at = -1, rd_total = 0;
  int cyc = 0, last_wen_cyc = 0, first_ren_cyc = 0, last_racc_cyc = 0;
  int done_total = 0, both_hi = 0;
  logic rd_en_prev = 1'b0;
  logic m_wacc, m_racc;

  assign full   = (cnt >= depth);
  assign empty  = (cnt == 0);
  assign m_wacc = fifo_wr_en & ~full & ~rst_busy;
  assign m_racc = fifo_rd_en & ~empty & ~rst_busy;

  always @(posedge sys_clk) begin
    cyc        <= cyc + 1;
    rd_en_prev <= fifo_rd_en;
    if (fifo_wr_en) last_wen_cyc <= cyc;
    if (fifo_rd_en && !rd_en_prev) first_ren_cyc <= cyc;
    if (fifo_wr_en && fifo_rd_en) both_hi <= both_hi + 1;
    if (done) done_total <= done_total + 1;
    fifo_rd_data <= stage1;
    if (rst_busy) begin
      cnt <= 0;
      wp  <= 8'h00;
      rp  <= 8'h00;
    end else begin
      if (m_wacc) begin
        mem[wp] <= fifo_wr_data;
        wp      <= wp + 8'd1;
        wr_log.push_back(fifo_wr_data);
      end
      if (m_racc) begin
        stage1        <= (rd_total == corrupt_at) ? (mem[rp] ^ 8'h01) : mem[rp];
        rp            <= rp + 8'd1;
        rd_total      <= rd_total + 1;
        last_racc_cyc <= cyc;
      end
      cnt <= cnt + (m_wacc ? 1 : 0) - (m_racc ? 1 : 0);
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (!done && k < 4000);
    chk(name, int'(done), 1);
  endtask

  typedef struct {
    int         depth;
    int         corrupt;
    int         abort_after;
    int         exp_wr;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
    int         exp_rd;
    int         exp_loop;
    int         exp_err;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int wr_base, rd_base, nw, seq_err, k;
    logic [7:0] e;

    // Loop 3 is aborted by rst_busy after 30 writes (0x40..0x5D), then restarts at 0x5E.
    vecs[0] = '{256, -1,  0, 256, 8'h00, 8'hFF, 256, 1, 0};
    vecs[1] = '{ 64, 10,  0,  64, 8'h00, 8'h3F,  64, 2, ERR_EXP};
    vecs[2] = '{ 64, -1, 30,  64, 8'h5E, 8'h9D,  64, 3, ERR_EXP};

    sys_rst  = 1'b1;
    start    = 1'b0;
    rst_busy = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_wr_en",   int'(fifo_wr_en),   0);
    chk("rst_rd_en",   int'(fifo_rd_en),   0);
    chk("rst_wr_data", int'(fifo_wr_data), 0);
    chk("rst_busy_o",  int'(busy),         0);
    chk("rst_done",    int'(done),         0);
    chk("rst_loop",    int'(loop_cnt),     0);
    chk("rst_err",     int'(err_cnt),      0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("idle_no_start", int'(busy), 0);

    wr_base = wr_log.size();
    rd_base = rd_total;
    for (int i = 0; i < 3; i++) begin
      depth      = vecs[i].depth;
      corrupt_at = (vecs[i].corrupt >= 0) ? rd_base + vecs[i].corrupt : -1;
      start      = 1'b1;

      if (vecs[i].abort_after > 0) begin
        k = 0;
        while ((wr_log.size() - wr_base) < vecs[i].abort_after && k < 2000) begin
          @(negedge sys_clk);
          k++;
        end
        chk("abort_wr_cnt", wr_log.size() - wr_base, vecs[i].abort_after);
        chk("abort_first_wr", (wr_log.size() > wr_base) ? int'(wr_log[wr_base]) : -1, 'h40);
        rst_busy = 1'b1;
        @(negedge sys_clk);
        chk("abort_wr_en", int'(fifo_wr_en), 0);
        chk("abort_rd_en", int'(fifo_rd_en), 0);
        chk("abort_busy",  int'(busy),       0);
        repeat (4) @(negedge sys_clk);
        chk("abort_busy_hold", int'(busy),     0);
        chk("abort_loop_cnt",  int'(loop_cnt), vecs[i].exp_loop - 1);
        rst_busy = 1'b0;
        wr_base  = wr_log.size();
        rd_base  = rd_total;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("abort_restart", int'(busy), 1);
      end

      wait_done($sformatf("L%0d_done", i + 1));
      nw = wr_log.size() - wr_base;
      chk($sformatf("L%0d_writes", i + 1), nw, vecs[i].exp_wr);
      chk($sformatf("L%0d_first_wr", i + 1), (nw > 0) ? int'(wr_log[wr_base]) : -1,
          int'(vecs[i].exp_first));
      chk($sformatf("L%0d_last_wr", i + 1), (nw > 0) ? int'(wr_log[$]) : -1,
          int'(vecs[i].exp_last));
      seq_err = 0;
      for (int j = 0; j < nw; j++) begin
        e = vecs[i].exp_first + 8'(j);
        if (wr_log[wr_base + j] != e) seq_err++;
      end
      chk($sformatf("L%0d_wr_seq", i + 1), seq_err, 0);
      chk($sformatf("L%0d_reads", i + 1), rd_total - rd_base, vecs[i].exp_rd);
      chk($sformatf("L%0d_loop_cnt", i + 1), int'(loop_cnt), vecs[i].exp_loop);
      chk($sformatf("L%0d_err_cnt", i + 1), int'(err_cnt), vecs[i].exp_err);
      chk($sformatf("L%0d_settle_gap", i + 1), first_ren_cyc - last_wen_cyc - 1, SETTLE);
      chk_rng($sformatf("L%0d_rd_exit", i + 1), cyc - last_racc_cyc, LAT + 1, LAT + 3);
      wr_base = wr_log.size();
      rd_base = rd_total;
    end

    // start stays high: LOOP_MAX must hold the sequencer in IDLE
    repeat (20) @(negedge sys_clk);
    chk("end_busy",       int'(busy),       0);
    chk("end_wr_en",      int'(fifo_wr_en), 0);
    chk("end_loop_cnt",   int'(loop_cnt),   LOOPS);
    chk("end_done_total", done_total,       LOOPS);
    chk("end_no_overlap", both_hi,          0);
    chk("end_no_writes",  wr_log.size() - wr_base, 0);
    start = 1'b0;
    repeat (3) @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
